// File: rtl/arp_cam_pkg.sv
// rtl/arp_cam_pkg.sv - shared widths, op/status codes and FSM states for the ARP CAM
package arp_cam_pkg;

   localparam int KEY_W   = 32;
   localparam int VAL_W   = 48;
   localparam int ENTRY_W = 1 + KEY_W + VAL_W;

   typedef enum logic [1:0] {
      OP_LOOKUP  = 2'b00,
      OP_INSERT  = 2'b01,
      OP_DELETE  = 2'b10,
      OP_LOOKUP2 = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_MISS = 2'b01,
      ST_FULL = 2'b10
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HASH,
      S_READ,
      S_CMP,
      S_RESP
   } state_t;

endpackage

// File: rtl/arp_cam_bank.sv
// rtl/arp_cam_bank.sv - one CAM way: valid flop vector plus key/value RAM, 1 read and 1 write port
module arp_cam_bank
   import arp_cam_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [KEY_W-1:0] rd_key,
   output logic [VAL_W-1:0] rd_value,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_valid,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [VAL_W-1:0] wr_value
);

   localparam int DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0]       valid_q;
   logic [KEY_W+VAL_W-1:0] mem [DEPTH];

   // Valid bits are the only table state cleared by reset; a delete only drops valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= wr_valid;
      end
   end

   // Key/value storage is written only on insert; read data is registered (1-cycle latency).
   always_ff @(posedge clk) begin
      if (wr_en && wr_valid) begin
         mem[wr_idx] <= {wr_key, wr_value};
      end
      {rd_key, rd_value} <= mem[rd_idx];
   end

   // Registered valid read, aligned with the RAM data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= valid_q[rd_idx];
      end
   end

endmodule

// File: rtl/arp_cam_lookup.sv
// rtl/arp_cam_lookup.sv - 2-way hashed ARP CAM; ARP_CAM_STATS_EN adds HitCnt/MissCnt/FullCnt
module arp_cam_lookup
   import arp_cam_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [1:0]  ReqOp,
   input  logic [31:0] ReqKey,
   input  logic [47:0] ReqValue,
   output logic [31:0] HashKey,
   input  logic [47:0] Hash,
   output logic        RspValid,
   input  logic        RspReady,
   output logic        RspHit,
   output logic [47:0] RspValue,
   output logic [1:0]  RspStatus
`ifdef ARP_CAM_STATS_EN
   ,
   output logic [31:0] HitCnt,
   output logic [31:0] MissCnt,
   output logic [31:0] FullCnt
`endif
);

   state_t             state_q, state_d;
   op_t                op_q;
   logic [KEY_W-1:0]   key_q;
   logic [VAL_W-1:0]   value_q;
   logic [IDX_W-1:0]   idx0_q, idx1_q;
   logic               rsp_hit_q;
   logic [VAL_W-1:0]   rsp_value_q;
   status_t            rsp_status_q;

   logic               b0_valid, b1_valid;
   logic [KEY_W-1:0]   b0_key, b1_key;
   logic [VAL_W-1:0]   b0_value, b1_value;

   logic               m0, m1, hit;
   logic [VAL_W-1:0]   hit_value;
   logic               wr0, wr1, wr_valid;
   status_t            status_d;
   logic               hash_unused;

   assign hash_unused = ^Hash[47:2*IDX_W];
   assign HashKey     = key_q;
   assign RspHit      = rsp_hit_q;
   assign RspValue    = rsp_value_q;
   assign RspStatus   = rsp_status_q;

   assign m0        = b0_valid && (b0_key == key_q);
   assign m1        = b1_valid && (b1_key == key_q);
   assign hit       = m0 || m1;
   assign hit_value = m0 ? b0_value : (m1 ? b1_value : '0);

   arp_cam_bank #(.IDX_W(IDX_W)) u_bank0 (
      .clk(Clk), .rst(Rst), .rd_idx(idx0_q),
      .rd_valid(b0_valid), .rd_key(b0_key), .rd_value(b0_value),
      .wr_en((state_q == S_CMP) && wr0 && !Rst), .wr_idx(idx0_q),
      .wr_valid(wr_valid), .wr_key(key_q), .wr_value(value_q)
   );

   arp_cam_bank #(.IDX_W(IDX_W)) u_bank1 (
      .clk(Clk), .rst(Rst), .rd_idx(idx1_q),
      .rd_valid(b1_valid), .rd_key(b1_key), .rd_value(b1_value),
      .wr_en((state_q == S_CMP) && wr1 && !Rst), .wr_idx(idx1_q),
      .wr_valid(wr_valid), .wr_key(key_q), .wr_value(value_q)
   );

   // Compare-stage decision: which way to write and what status to report.
   always_comb begin
      wr0      = 1'b0;
      wr1      = 1'b0;
      wr_valid = 1'b0;
      status_d = hit ? ST_OK : ST_MISS;
      case (op_q)
         OP_INSERT: begin
            wr_valid = 1'b1;
            status_d = ST_OK;
            if (m0)             wr0 = 1'b1;
            else if (m1)        wr1 = 1'b1;
            else if (!b0_valid) wr0 = 1'b1;
            else if (!b1_valid) wr1 = 1'b1;
            else                status_d = ST_FULL;
         end
         OP_DELETE: begin
            if (m0)      wr0 = 1'b1;
            else if (m1) wr1 = 1'b1;
         end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      ReqReady = 1'b0;
      RspValid = 1'b0;
      case (state_q)
         S_IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) state_d = S_HASH;
         end
         S_HASH: state_d = S_READ;
         S_READ: state_d = S_CMP;
         S_CMP:  state_d = S_RESP;
         S_RESP: begin
            RspValid = 1'b1;
            if (RspReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, bank index capture and response registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         op_q         <= OP_LOOKUP;
         key_q        <= '0;
         value_q      <= '0;
         idx0_q       <= '0;
         idx1_q       <= '0;
         rsp_hit_q    <= 1'b0;
         rsp_value_q  <= '0;
         rsp_status_q <= ST_OK;
      end else begin
         if (state_q == S_IDLE && ReqValid) begin
            op_q    <= op_t'(ReqOp);
            key_q   <= ReqKey;
            value_q <= ReqValue;
         end
         if (state_q == S_HASH) begin
            idx0_q <= Hash[IDX_W-1:0];
            idx1_q <= Hash[2*IDX_W-1:IDX_W];
         end
         if (state_q == S_CMP) begin
            rsp_hit_q    <= hit;
            rsp_value_q  <= hit_value;
            rsp_status_q <= status_d;
         end
      end
   end

`ifdef ARP_CAM_STATS_EN
   // Saturating result counters, bumped once per request in the compare stage.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         HitCnt  <= '0;
         MissCnt <= '0;
         FullCnt <= '0;
      end else if (state_q == S_CMP) begin
         if (hit && HitCnt != 32'hFFFF_FFFF)                   HitCnt  <= HitCnt + 32'd1;
         if (status_d == ST_MISS && MissCnt != 32'hFFFF_FFFF)  MissCnt <= MissCnt + 32'd1;
         if (status_d == ST_FULL && FullCnt != 32'hFFFF_FFFF)  FullCnt <= FullCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arp_cam_lookup.sv
// tb/tb_arp_cam_lookup.sv - scoreboard bench for arp_cam_lookup (real hash and Hash=0 stub)
module tb_arp_cam_lookup;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        ReqValid;
   logic        ReqReady;
   logic [1:0]  ReqOp;
   logic [31:0] ReqKey;
   logic [47:0] ReqValue;
   logic [31:0] HashKey;
   logic [47:0] Hash;
   logic        RspValid;
   logic        RspReady;
   logic        RspHit;
   logic [47:0] RspValue;
   logic [1:0]  RspStatus;
`ifdef ARP_CAM_STATS_EN
   logic [31:0] HitCnt, MissCnt, FullCnt;
`endif

   typedef struct {
      logic        hit;
      logic [47:0] value;
      logic [1:0]  status;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic use_stub = 1'b0;
   logic prev_v = 1'b0;

   localparam logic [1:0] LK = 2'b00, INS = 2'b01, DEL = 2'b10;
   localparam logic [1:0] OK = 2'b00, MISS = 2'b01, FULL = 2'b10;

   function automatic logic [47:0] bench_hash(input logic [31:0] k);
      logic [31:0] m;
      m = k * 32'h9E37_79B1;
      return {k[15:0] ^ k[31:16], m ^ {m[15:0], m[31:16]}};
   endfunction

   assign Hash = use_stub ? 48'h0 : bench_hash(HashKey);

   arp_cam_lookup #(.IDX_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqOp(ReqOp), .ReqKey(ReqKey), .ReqValue(ReqValue),
      .HashKey(HashKey), .Hash(Hash),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspHit(RspHit), .RspValue(RspValue), .RspStatus(RspStatus)
`ifdef ARP_CAM_STATS_EN
      , .HitCnt(HitCnt), .MissCnt(MissCnt), .FullCnt(FullCnt)
`endif
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: latency check on RspValid rise, field compare on handshake.
   always @(negedge Clk) begin
      exp_t e;
      if (Rst) begin
         prev_v = 1'b0;
      end else begin
         if (RspValid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_rsp", 1, 0);
            else               chk("latency", cyc - q[0].acc, 4);
         end
         if (RspValid && RspReady && q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_hit", RspHit, e.hit);
            chk("rsp_value", RspValue, e.value);
            chk("rsp_status", RspStatus, e.status);
         end
         prev_v = RspValid;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] key, input logic [47:0] val,
                        input logic eh, input logic [47:0] ev, input logic [1:0] es);
      exp_t e;
      int n = 0;
      @(negedge Clk);
      while (!ReqReady && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!ReqReady) begin
         chk("req_ready_timeout", 0, 1);
         return;
      end
      ReqValid = 1'b1;
      ReqOp    = op;
      ReqKey   = key;
      ReqValue = val;
      e.hit = eh; e.value = ev; e.status = es; e.acc = cyc;
      q.push_back(e);
      @(negedge Clk);
      ReqValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
      @(negedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      logic        sv, sh, ok, rr_seen;
      logic [47:0] sval;
      logic [1:0]  sst;
      int          n;

      Rst = 1'b1; ReqValid = 1'b0; ReqOp = 2'b00; ReqKey = '0; ReqValue = '0; RspReady = 1'b1;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      chk("rst_req_ready", ReqReady, 1);
      chk("rst_rsp_valid", RspValid, 0);
      chk("rst_rsp_hit", RspHit, 0);
      chk("rst_rsp_value", RspValue, 0);
      chk("rst_rsp_status", RspStatus, 0);
      chk("rst_hash_key", HashKey, 0);

      // real hash
      issue(LK,  32'hC0A8_0001, 48'h0, 0, 48'h0, MISS);
      issue(INS, 32'h0A00_0001, 48'h0002_B3AA_BB01, 0, 48'h0, OK);
      issue(LK,  32'h0A00_0001, 48'h0, 1, 48'h0002_B3AA_BB01, OK);
      issue(INS, 32'h0000_0001, 48'h0A0A_0A0A_0A0A, 0, 48'h0, OK);
      issue(INS, 32'h0000_0001, 48'h0B0B_0B0B_0B0B, 1, 48'h0A0A_0A0A_0A0A, OK);
      issue(DEL, 32'h0000_0001, 48'h0, 1, 48'h0B0B_0B0B_0B0B, OK);
      issue(LK,  32'h0000_0001, 48'h0, 0, 48'h0, MISS);
      issue(DEL, 32'h0B00_0000, 48'h0, 0, 48'h0, MISS);
      issue(2'b11, 32'h0A00_0001, 48'h0, 1, 48'h0002_B3AA_BB01, OK);
      drain();

      // response back-pressure
      RspReady = 1'b0;
      issue(LK, 32'h0A00_0001, 48'h0, 1, 48'h0002_B3AA_BB01, OK);
      n = 0;
      while (!RspValid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("stall_rsp_seen", RspValid, 1);
      sv = RspValid; sh = RspHit; sval = RspValue; sst = RspStatus;
      ok = 1'b1; rr_seen = 1'b0;
      repeat (10) begin
         @(negedge Clk);
         if (RspValid !== sv || RspHit !== sh || RspValue !== sval || RspStatus !== sst) ok = 1'b0;
         if (ReqReady) rr_seen = 1'b1;
      end
      chk("stall_outputs_stable", ok, 1);
      chk("stall_req_ready_low", rr_seen, 0);
      RspReady = 1'b1;
      drain();

      // reset in READ aborts an insert and clears the table
      ReqValid = 1'b1; ReqOp = INS; ReqKey = 32'h0C00_0001; ReqValue = 48'h0000_0000_0111;
      @(negedge Clk);
      ReqValid = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      chk("abort_req_ready", ReqReady, 1);
      chk("abort_rsp_valid", RspValid, 0);
      repeat (6) @(negedge Clk);
      issue(LK, 32'h0C00_0001, 48'h0, 0, 48'h0, MISS);
      issue(LK, 32'h0A00_0001, 48'h0, 0, 48'h0, MISS);
      drain();

      // Hash stub: every key maps to index 0 in both ways
      use_stub = 1'b1;
      do_reset();
      issue(INS, 32'd1, 48'h111, 0, 48'h0, OK);
      issue(INS, 32'd2, 48'h222, 0, 48'h0, OK);
      issue(INS, 32'd3, 48'h333, 0, 48'h0, FULL);
      issue(LK,  32'd3, 48'h0,   0, 48'h0, MISS);
      issue(LK,  32'd2, 48'h0,   1, 48'h222, OK);
      drain();
`ifdef ARP_CAM_STATS_EN
      chk("stats_hit", HitCnt, 1);
      chk("stats_miss", MissCnt, 1);
      chk("stats_full", FullCnt, 1);
`endif
      issue(LK,  32'd1, 48'h0,    1, 48'h111, OK);
      issue(DEL, 32'd1, 48'h0,    1, 48'h111, OK);
      issue(INS, 32'd3, 48'h333,  0, 48'h0, OK);
      issue(LK,  32'd3, 48'h0,    1, 48'h333, OK);
      issue(INS, 32'd2, 48'h2222, 1, 48'h222, OK);
      issue(LK,  32'd2, 48'h0,    1, 48'h2222, OK);
      issue(INS, 32'd4, 48'h444,  0, 48'h0, FULL);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
